// File: rtl/vga_rx_monitor.sv
// Sink-side 640x480@60 VGA timing monitor: recovers (x, y), checks sync timing, reports lock/errors.
// Latency: pin sample at cycle n appears on all outputs at cycle n+2.
// Backpressure: none; the pixel stream is free-running and the monitor never stalls it.
module vga_rx_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iVGA_HS,
    input  logic       iVGA_VS,
    input  logic       iVGA_R,
    input  logic       iVGA_G,
    input  logic       iVGA_B,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oPix_valid,
    output logic       oRed,
    output logic       oGreen,
    output logic       oBlue,
    output logic       oFrame_start,
    output logic       oLocked,
    output logic       oH_err,
    output logic       oV_err,
    output logic [7:0] oErr_count
);

    localparam logic [9:0] H_TOTAL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_SW    = 10'(H_SYNC);
    localparam logic [9:0] V_SW    = 10'(V_SYNC);
    localparam logic [9:0] H_ST    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_ST    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

    state_t     state, state_nxt;
    logic       hs_a, vs_a, hs_d, vs_line;
    logic [2:0] rgb_a;
    logic [9:0] h_pos, v_pos, h_cur, v_cur;
    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       h_bad, v_bad, h_err, v_err;
    logic       frame_start, active, pix_vld;

    // Syncs reset high so that reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_a  <= 1'b1;
            vs_a  <= 1'b1;
            hs_d  <= 1'b1;
            rgb_a <= 3'b000;
        end else begin
            hs_a  <= iVGA_HS;
            vs_a  <= iVGA_VS;
            hs_d  <= hs_a;
            rgb_a <= {iVGA_R, iVGA_G, iVGA_B};
        end
    end

    always_comb begin
        hs_fall = hs_d & ~hs_a;
        hs_rise = ~hs_d & hs_a;
        vs_fall = hs_fall & vs_line & ~vs_a;
        vs_rise = hs_fall & ~vs_line & vs_a;

        h_cur = (h_pos == H_TOTAL) ? H_TOTAL : h_pos + 10'd1;
        if (hs_fall) begin
            h_cur = 10'd0;
        end
        v_cur = v_pos;
        if (vs_fall) begin
            v_cur = 10'd0;
        end else if (hs_fall) begin
            v_cur = (v_pos == V_TOTAL) ? V_TOTAL : v_pos + 10'd1;
        end

        // h_pos is the count of the previous cycle; h_cur is this cycle's position.
        h_bad = (hs_fall && h_pos != H_TOTAL - 10'd1)
             || (hs_rise && h_cur != H_SW)
             || (!hs_fall && h_cur == H_TOTAL && h_pos != H_TOTAL);
        v_bad = (vs_fall && state == LOCKED && v_pos != V_TOTAL - 10'd1)
             || (vs_rise && v_cur != V_SW)
             || (hs_fall && !vs_fall && v_cur == V_TOTAL && v_pos != V_TOTAL);
        h_err = (state != SEARCH) && h_bad;
        v_err = (state == V_ACQ || state == LOCKED) && v_bad;

        state_nxt   = state;
        frame_start = 1'b0;
        if (h_err || v_err) begin
            state_nxt = SEARCH;
        end else begin
            case (state)
                SEARCH:  if (hs_fall) state_nxt = H_ACQ;
                // Reaching a clean fall means both period and sync width were good.
                H_ACQ:   if (hs_fall) state_nxt = V_ACQ;
                V_ACQ: begin
                    if (vs_fall) begin
                        state_nxt   = LOCKED;
                        frame_start = 1'b1;
                    end
                end
                LOCKED:  frame_start = vs_fall;
                default: state_nxt = SEARCH;
            endcase
        end

        active  = (h_cur >= H_ST) && (h_cur < H_END) && (v_cur >= V_ST) && (v_cur < V_END);
        pix_vld = (state_nxt == LOCKED) && active;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SEARCH;
            h_pos   <= 10'd0;
            v_pos   <= 10'd0;
            vs_line <= 1'b1;
        end else begin
            state <= state_nxt;
            h_pos <= h_cur;
            v_pos <= v_cur;
            if (hs_fall) begin
                vs_line <= vs_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oX           <= 10'd0;
            oY           <= 10'd0;
            oPix_valid   <= 1'b0;
            oRed         <= 1'b0;
            oGreen       <= 1'b0;
            oBlue        <= 1'b0;
            oFrame_start <= 1'b0;
            oLocked      <= 1'b0;
            oH_err       <= 1'b0;
            oV_err       <= 1'b0;
            oErr_count   <= 8'd0;
        end else begin
            oPix_valid             <= pix_vld;
            oX                     <= pix_vld ? h_cur - H_ST : 10'd0;
            oY                     <= pix_vld ? v_cur - V_ST : 10'd0;
            {oRed, oGreen, oBlue}  <= pix_vld ? rgb_a : 3'b000;
            oFrame_start           <= frame_start;
            oLocked                <= (state_nxt == LOCKED);
            oH_err                 <= h_err;
            oV_err                 <= v_err;
            if ((h_err || v_err) && oErr_count != 8'hFF) begin
                oErr_count <= oErr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a shrunken raster: random colours, scoreboard of driven pixels,
// per-scenario event counting for lock, frame start and error behaviour.
module tb_vga_rx_monitor;

    localparam int HA = 8, HF = 2, HSW = 4, HB = 3;
    localparam int VA = 6, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int HST = HSW + HB;
    localparam int VST = VSW + VB;
    localparam int NPIX = HA * VA;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
    logic [9:0] oX, oY;
    logic       oPix_valid, oRed, oGreen, oBlue, oFrame_start, oLocked, oH_err, oV_err;
    logic [7:0] oErr_count;

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .iVGA_HS(hs), .iVGA_VS(vs), .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
        .oX(oX), .oY(oY), .oPix_valid(oPix_valid),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oFrame_start(oFrame_start), .oLocked(oLocked),
        .oH_err(oH_err), .oV_err(oV_err), .oErr_count(oErr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [2:0] pix_mem [NPIX];
    int         pix_cyc [NPIX];
    int frame_cyc = -100;
    int n_pix = 0, n_fs = 0, n_herr = 0, n_verr = 0;
    int exp_x = 0, exp_y = 0;
    logic prev_locked = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: every emitted pixel must be the next raster position, carry the colour driven
    // at that position, and appear two cycles after it was driven.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (oFrame_start) begin
                    n_fs++;
                    vectors++;
                    if (cyc != frame_cyc + 2) begin
                        miscompares++;
                        $display("FAIL frame_start_latency got cyc=%0d want=%0d", cyc, frame_cyc + 2);
                    end
                    exp_x = 0;
                    exp_y = 0;
                end
                if (oH_err) n_herr++;
                if (oV_err) n_verr++;
                if (prev_locked && !oLocked) begin
                    vectors++;
                    if (!(oH_err || oV_err)) begin
                        miscompares++;
                        $display("FAIL lock_drop_without_err got err=%b%b want an error pulse", oH_err, oV_err);
                    end
                end
                if (!prev_locked && oLocked) begin
                    vectors++;
                    if (!oFrame_start) begin
                        miscompares++;
                        $display("FAIL lock_rise_without_frame_start got fs=%b want 1", oFrame_start);
                    end
                end
                if (oPix_valid) begin
                    n_pix++;
                    vectors++;
                    if (int'(oX) != exp_x || int'(oY) != exp_y) begin
                        miscompares++;
                        $display("FAIL pix_coord got (%0d,%0d) want (%0d,%0d)", oX, oY, exp_x, exp_y);
                    end else begin
                        vectors += 2;
                        if ({oRed, oGreen, oBlue} !== pix_mem[exp_y * HA + exp_x]) begin
                            miscompares++;
                            $display("FAIL pix_colour at (%0d,%0d) got %b want %b", oX, oY,
                                     {oRed, oGreen, oBlue}, pix_mem[exp_y * HA + exp_x]);
                        end
                        if (cyc - pix_cyc[exp_y * HA + exp_x] != 2) begin
                            miscompares++;
                            $display("FAIL pix_latency got %0d want 2", cyc - pix_cyc[exp_y * HA + exp_x]);
                        end
                    end
                    exp_x++;
                    if (exp_x == HA) begin
                        exp_x = 0;
                        exp_y++;
                    end
                end else begin
                    vectors++;
                    if ({oX, oY, oRed, oGreen, oBlue} !== 23'd0) begin
                        miscompares++;
                        $display("FAIL idle_outputs_zero got x=%0d y=%0d rgb=%b want 0", oX, oY, {oRed, oGreen, oBlue});
                    end
                end
            end
            prev_locked = oLocked;
        end
    end

    // One pixel clock of pin stimulus; l/h locate the pixel in the frame (l < 0: no frame position).
    task automatic drive_pix(input logic hs_v, input logic vs_v, input int l, input int h);
        @(posedge clk);
        #1;
        hs = hs_v;
        vs = vs_v;
        {r, g, b} = 3'($urandom);
        if (l >= VST && l < VST + VA && h >= HST && h < HST + HA) begin
            pix_mem[(l - VST) * HA + (h - HST)] = {r, g, b};
            pix_cyc[(l - VST) * HA + (h - HST)] = cyc;
        end
        if (l == 0 && h == 0 && vs_v == 1'b0) frame_cyc = cyc;
    endtask

    task automatic drive_line(input int len, input int sw, input logic vs_v, input int l);
        for (int h = 0; h < len; h++) drive_pix(h < sw ? 1'b0 : 1'b1, vs_v, l, h);
    endtask

    task automatic drive_frame(input int short_l, input int narrow_l, input bit vs_hold);
        for (int l = 0; l < VT; l++)
            drive_line(l == short_l ? HT - 1 : HT, l == narrow_l ? HSW - 1 : HSW,
                       vs_hold ? 1'b1 : (l < VSW ? 1'b0 : 1'b1), l);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i < 4) {hs, vs, r, g, b} = 5'($urandom);
            else begin
                reset = 1'b1;
                {hs, vs, r, g, b} = 5'b11000;
            end
            #1;
            vectors++;
            if ({oX, oY, oPix_valid, oRed, oGreen, oBlue, oFrame_start, oLocked, oH_err, oV_err, oErr_count} !== 36'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d got locked=%b err_count=%0d x=%0d want all 0", i, oLocked, oErr_count, oX);
            end
        end
    endtask

    task automatic test_nominal();
        int b_fs, b_pix;
        b_fs = n_fs;
        b_pix = n_pix;
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b0 || n_fs != b_fs || n_pix != b_pix) begin
            miscompares++;
            $display("FAIL acquire_frame got locked=%b fs=%0d pix=%0d want 0/0/0", oLocked, n_fs - b_fs, n_pix - b_pix);
        end
        for (int f = 0; f < 3; f++) begin
            b_fs = n_fs;
            b_pix = n_pix;
            drive_frame(-1, -1, 0);
            vectors++;
            if (oLocked !== 1'b1 || n_fs - b_fs != 1 || n_pix - b_pix != NPIX) begin
                miscompares++;
                $display("FAIL nominal_frame%0d got locked=%b fs=%0d pix=%0d want 1/1/%0d",
                         f, oLocked, n_fs - b_fs, n_pix - b_pix, NPIX);
            end
        end
        vectors++;
        if (oErr_count !== 8'd0 || n_herr != 0 || n_verr != 0) begin
            miscompares++;
            $display("FAIL nominal_no_errors got count=%0d herr=%0d verr=%0d want 0", oErr_count, n_herr, n_verr);
        end
    endtask

    task automatic test_short_line();
        int b_fs, b_pix, b_h, b_v, l;
        l = int'($urandom_range(VT - 4, VSW));
        b_fs = n_fs; b_h = n_herr; b_v = n_verr;
        drive_frame(l, -1, 0);
        vectors++;
        if (n_herr - b_h != 1 || n_verr != b_v || oLocked !== 1'b0 || oErr_count !== 8'd1 || n_fs - b_fs != 1) begin
            miscompares++;
            $display("FAIL short_line l=%0d got herr=%0d verr=%0d locked=%b count=%0d fs=%0d want 1/0/0/1/1",
                     l, n_herr - b_h, n_verr - b_v, oLocked, oErr_count, n_fs - b_fs);
        end
        b_fs = n_fs; b_pix = n_pix;
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b1 || n_fs - b_fs != 1 || n_pix - b_pix != NPIX) begin
            miscompares++;
            $display("FAIL short_line_relock got locked=%b fs=%0d pix=%0d want 1/1/%0d", oLocked, n_fs - b_fs, n_pix - b_pix, NPIX);
        end
    endtask

    task automatic test_narrow_sync();
        int b_fs, b_h, l;
        l = int'($urandom_range(VT - 4, VSW));
        b_h = n_herr;
        drive_frame(-1, l, 0);
        vectors++;
        if (n_herr - b_h != 1 || oLocked !== 1'b0 || oErr_count !== 8'd2) begin
            miscompares++;
            $display("FAIL narrow_sync l=%0d got herr=%0d locked=%b count=%0d want 1/0/2", l, n_herr - b_h, oLocked, oErr_count);
        end
        b_fs = n_fs;
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b1 || n_fs - b_fs != 1) begin
            miscompares++;
            $display("FAIL narrow_sync_relock got locked=%b fs=%0d want 1/1", oLocked, n_fs - b_fs);
        end
    endtask

    task automatic test_vs_hold();
        int b_fs, b_h, b_v, b_pix;
        b_fs = n_fs; b_h = n_herr; b_v = n_verr;
        drive_frame(-1, -1, 1);
        vectors++;
        if (n_verr - b_v != 1 || n_herr != b_h || n_fs != b_fs || oLocked !== 1'b0 || oErr_count !== 8'd3) begin
            miscompares++;
            $display("FAIL vs_hold got verr=%0d herr=%0d fs=%0d locked=%b count=%0d want 1/0/0/0/3",
                     n_verr - b_v, n_herr - b_h, n_fs - b_fs, oLocked, oErr_count);
        end
        b_fs = n_fs; b_pix = n_pix;
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b1 || n_fs - b_fs != 1 || n_pix - b_pix != NPIX || n_verr - b_v != 1) begin
            miscompares++;
            $display("FAIL vs_hold_relock got locked=%b fs=%0d pix=%0d verr=%0d want 1/1/%0d/1",
                     oLocked, n_fs - b_fs, n_pix - b_pix, n_verr - b_v, NPIX);
        end
    endtask

    task automatic test_reset_midframe();
        int b_fs, b_pix, b_h, b_v;
        for (int l = 0; l < 8; l++) drive_line(HT, HSW, l < VSW ? 1'b0 : 1'b1, l);
        b_fs = n_fs; b_h = n_herr; b_v = n_verr;
        for (int h = 0; h < HT; h++) begin
            drive_pix(h < HSW ? 1'b0 : 1'b1, 1'b1, 8, h);
            if (h == 10) reset = 1'b0;
            if (h == 13) reset = 1'b1;
            if (h >= 10 && h < 13) begin
                #1;
                vectors++;
                if ({oX, oY, oPix_valid, oRed, oGreen, oBlue, oFrame_start, oLocked, oH_err, oV_err, oErr_count} !== 36'd0) begin
                    miscompares++;
                    $display("FAIL midframe_reset_outputs h=%0d got locked=%b count=%0d want all 0", h, oLocked, oErr_count);
                end
            end
        end
        for (int l = 9; l < VT; l++) drive_line(HT, HSW, 1'b1, l);
        vectors++;
        if (oLocked !== 1'b0 || n_fs != b_fs) begin
            miscompares++;
            $display("FAIL midframe_reset_unlocked got locked=%b fs=%0d want 0/0", oLocked, n_fs - b_fs);
        end
        b_pix = n_pix;
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b1 || n_fs - b_fs != 1 || n_pix - b_pix != NPIX || oErr_count !== 8'd0
            || n_herr != b_h || n_verr != b_v) begin
            miscompares++;
            $display("FAIL midframe_reset_relock got locked=%b fs=%0d pix=%0d count=%0d want 1/1/%0d/0",
                     oLocked, n_fs - b_fs, n_pix - b_pix, oErr_count, NPIX);
        end
    endtask

    task automatic test_err_saturate();
        int b_fs, b_h, b_v, n_short;
        n_short = 520;
        b_h = n_herr; b_v = n_verr;
        for (int l = 0; l < 3; l++) drive_line(HT, HSW, l < VSW ? 1'b0 : 1'b1, l);
        for (int i = 0; i < n_short; i++) drive_line(HT - 1, HSW, 1'b1, -1);
        // Each error sends the monitor back to search, so only every other early line start is checked.
        vectors++;
        if (n_herr - b_h != (n_short + 1) / 2 || oErr_count !== 8'd255 || n_verr != b_v || oLocked !== 1'b0) begin
            miscompares++;
            $display("FAIL err_saturate got herr=%0d count=%0d verr=%0d locked=%b want %0d/255/0/0",
                     n_herr - b_h, oErr_count, n_verr - b_v, oLocked, (n_short + 1) / 2);
        end
        b_fs = n_fs;
        drive_frame(-1, -1, 0);
        drive_frame(-1, -1, 0);
        vectors++;
        if (oLocked !== 1'b1 || n_fs - b_fs != 1 || oErr_count !== 8'd255 || n_herr - b_h != (n_short + 1) / 2) begin
            miscompares++;
            $display("FAIL err_saturate_relock got locked=%b fs=%0d count=%0d want 1/1/255", oLocked, n_fs - b_fs, oErr_count);
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            pix_mem[i] = 3'b000;
            pix_cyc[i] = 0;
        end
        test_reset();
        test_nominal();
        test_short_line();
        test_narrow_sync();
        test_vs_hold();
        test_reset_midframe();
        test_err_saturate();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
